// File: rtl/pipe_addsub_n_pkg.sv
// Shared helpers for the pipelined add/subtract unit: slice width derivation
// and the constants used when capturing operands into the first stage.
package pipe_addsub_n_pkg;

   localparam int   MIN_SLICES   = 1;
   // Subtraction is A + ~B + 1, so the first-stage carry is forced high.
   localparam logic SUB_CARRY_IN = 1'b1;

   function automatic int slice_w(input int width, input int slices);
      return (slices > 0) ? (width / slices) : width;
   endfunction

endpackage

// File: rtl/pipe_addsub_n_add_slice.sv
// Combinational SLICE_W-bit adder slice; also reports the carry into its MSB
// so the final stage can derive signed overflow.
module pipe_addsub_n_add_slice
   import pipe_addsub_n_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         c_i,
   output logic [W-1:0] sum_o,
   output logic         c_o,
   output logic         c_msb_o
);

   logic [W:0] w_full;

   assign w_full  = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
   assign sum_o   = w_full[W-1:0];
   assign c_o     = w_full[W];
   // Sum MSB is a^b^cin at that bit, so the carry into it falls out by XOR.
   assign c_msb_o = w_full[W-1] ^ a_i[W-1] ^ b_i[W-1];

endmodule

// File: rtl/pipe_addsub_n.sv
// Pipelined WIDTH-bit add/subtract: one SLICE_W-bit slice of the carry chain
// per stage, valid/ready on both sides with per-stage backpressure.
module pipe_addsub_n
   import pipe_addsub_n_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int SLICES = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_in_i,
   input  logic             sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             c_out_o,
   output logic             ovf_o
);

   localparam int SW = slice_w(WIDTH, SLICES);

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // in_ready_o depends on out_ready_i and stage state only, never on in_valid_i.

   if (SLICES < MIN_SLICES || (WIDTH % SLICES) != 0) begin : g_bad_params
      $error("pipe_addsub_n: SLICES must be >= 1 and divide WIDTH");
   end

   logic [SLICES-1:0]         r_v;
   logic [SLICES-1:0]         r_c;
   logic [WIDTH-1:0]          r_a   [SLICES];
   logic [WIDTH-1:0]          r_b   [SLICES];
   logic [WIDTH-1:0]          r_sum [SLICES];

   logic [SLICES-1:0]         w_load;
   logic [SLICES-1:0]         w_cout;
   logic [SLICES-1:0]         w_cmsb;
   logic [SLICES-1:0][SW-1:0] w_slice;
   logic [WIDTH-1:0]          w_ins [SLICES];

   for (genvar k = 0; k < SLICES; k++) begin : g_stage
      // A stage can load if it or any stage after it is empty, or the tail pops.
      assign w_load[k] = out_ready_i || !(&r_v[SLICES-1:k]);

      pipe_addsub_n_add_slice #(.W(SW)) u_slice (
         .a_i     (r_a[k][k*SW +: SW]),
         .b_i     (r_b[k][k*SW +: SW]),
         .c_i     (r_c[k]),
         .sum_o   (w_slice[k]),
         .c_o     (w_cout[k]),
         .c_msb_o (w_cmsb[k])
      );

      // r_sum[k] only ever holds bits below slice k, so OR-ing inserts the slice.
      assign w_ins[k] = r_sum[k] | (WIDTH'(w_slice[k]) << (k*SW));
   end

   if (SLICES > 1) begin : g_unused
      logic w_unused_cmsb;
      assign w_unused_cmsb = ^w_cmsb[SLICES-2:0];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_v <= '0;
         r_c <= '0;
         for (int k = 0; k < SLICES; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
         end
      end else begin
         if (w_load[0]) begin
            r_v[0] <= in_valid_i;
            if (in_valid_i) begin
               r_a[0]   <= a_i;
               r_b[0]   <= sub_i ? ~b_i : b_i;
               r_c[0]   <= sub_i ? SUB_CARRY_IN : c_in_i;
               r_sum[0] <= '0;
            end
         end
         for (int k = 1; k < SLICES; k++) begin
            if (w_load[k]) begin
               r_v[k] <= r_v[k-1];
               if (r_v[k-1]) begin
                  r_a[k]   <= r_a[k-1];
                  r_b[k]   <= r_b[k-1];
                  r_sum[k] <= w_ins[k-1];
                  r_c[k]   <= w_cout[k-1];
               end
            end
         end
      end
   end

   assign in_ready_o  = w_load[0];
   assign out_valid_o = r_v[SLICES-1];
   assign sum_o       = w_ins[SLICES-1];
   assign c_out_o     = w_cout[SLICES-1];
   assign ovf_o       = w_cmsb[SLICES-1] ^ w_cout[SLICES-1];

endmodule

// File: tb/tb_pipe_addsub_n.sv
// Bench for pipe_addsub_n in three configurations: 16/4, 16/1 and 32/8.
// Expected results come from a plain-arithmetic reference model and queues.
module tb_pipe_addsub_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid;
   logic        c_in;
   logic        sub;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;
   int          sel;

   logic [2:0]  iv;
   logic [2:0]  rdy_w;
   logic [2:0]  ov_w;
   logic [2:0]  co_w;
   logic [2:0]  of_w;
   logic [15:0] sum0;
   logic [15:0] sum1;
   logic [31:0] sum2;

   logic        o_in_ready;
   logic        o_out_valid;
   logic        o_cout;
   logic        o_ovf;
   logic [31:0] o_sum;

   int n_vec = 0;
   int n_err = 0;

   logic [33:0] exp_q[$];
   logic [33:0] got_q[$];

   assign iv[0] = in_valid && (sel == 0);
   assign iv[1] = in_valid && (sel == 1);
   assign iv[2] = in_valid && (sel == 2);

   pipe_addsub_n #(.WIDTH(16), .SLICES(4)) dut0 (
      .clk_i(clk), .reset_i(reset), .in_valid_i(iv[0]), .in_ready_o(rdy_w[0]),
      .a_i(a[15:0]), .b_i(b[15:0]), .c_in_i(c_in), .sub_i(sub),
      .out_valid_o(ov_w[0]), .out_ready_i(out_ready), .sum_o(sum0),
      .c_out_o(co_w[0]), .ovf_o(of_w[0])
   );

   pipe_addsub_n #(.WIDTH(16), .SLICES(1)) dut1 (
      .clk_i(clk), .reset_i(reset), .in_valid_i(iv[1]), .in_ready_o(rdy_w[1]),
      .a_i(a[15:0]), .b_i(b[15:0]), .c_in_i(c_in), .sub_i(sub),
      .out_valid_o(ov_w[1]), .out_ready_i(out_ready), .sum_o(sum1),
      .c_out_o(co_w[1]), .ovf_o(of_w[1])
   );

   pipe_addsub_n #(.WIDTH(32), .SLICES(8)) dut2 (
      .clk_i(clk), .reset_i(reset), .in_valid_i(iv[2]), .in_ready_o(rdy_w[2]),
      .a_i(a), .b_i(b), .c_in_i(c_in), .sub_i(sub),
      .out_valid_o(ov_w[2]), .out_ready_i(out_ready), .sum_o(sum2),
      .c_out_o(co_w[2]), .ovf_o(of_w[2])
   );

   always_comb begin
      o_in_ready  = rdy_w[0];
      o_out_valid = ov_w[0];
      o_cout      = co_w[0];
      o_ovf       = of_w[0];
      o_sum       = {16'h0, sum0};
      if (sel == 1) begin
         o_in_ready  = rdy_w[1];
         o_out_valid = ov_w[1];
         o_cout      = co_w[1];
         o_ovf       = of_w[1];
         o_sum       = {16'h0, sum1};
      end else if (sel == 2) begin
         o_in_ready  = rdy_w[2];
         o_out_valid = ov_w[2];
         o_cout      = co_w[2];
         o_ovf       = of_w[2];
         o_sum       = sum2;
      end
   end

   function automatic int cfg_w(input int s);
      return (s == 2) ? 32 : 16;
   endfunction

   function automatic int cfg_s(input int s);
      return (s == 0) ? 4 : ((s == 1) ? 1 : 8);
   endfunction

   // Reference: width-w two's-complement add/subtract with carry and overflow.
   function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic mc, input logic ms, input int w);
      longint unsigned mask, ua, ub, full, sum;
      logic cout, sa, sb, ss, ovf;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'h0, ma} & mask;
      ub   = (ms ? ~{32'h0, mb} : {32'h0, mb}) & mask;
      full = ua + ub + (ms ? 64'd1 : {63'd0, mc});
      sum  = full & mask;
      cout = full[w];
      sa   = ua[w-1];
      sb   = ub[w-1];
      ss   = sum[w-1];
      ovf  = (sa == sb) && (ss != sa);
      return {ovf, cout, sum[31:0]};
   endfunction

   // Called between negedge and posedge: records transfers, then advances.
   task automatic xfer();
      if (in_valid && o_in_ready) exp_q.push_back(model(a, b, c_in, sub, cfg_w(sel)));
      if (o_out_valid && out_ready) got_q.push_back({o_ovf, o_cout, o_sum});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #0;
         n_vec++;
         if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid sel=%0d got=%b exp=0", s, o_out_valid); end
         n_vec++;
         if (o_sum !== 32'h0) begin n_err++; $display("FAIL reset_sum sel=%0d got=%h exp=0", s, o_sum); end
         n_vec++;
         if (o_cout !== 1'b0) begin n_err++; $display("FAIL reset_cout sel=%0d got=%b exp=0", s, o_cout); end
         n_vec++;
         if (o_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf sel=%0d got=%b exp=0", s, o_ovf); end
         n_vec++;
         if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, o_in_ready); end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic(input int s);
      logic [31:0] mask;
      logic [33:0] expv;
      int lat;
      sel = s;
      do_reset();
      mask = (cfg_w(s) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      for (int i = 0; i < 3; i++) begin
         c_in = 1'b0;
         sub  = 1'b0;
         case (i)
            0: begin a = mask;      b = 32'd1; expv = {1'b0, 1'b1, 32'h0}; end
            1: begin a = mask >> 1; b = 32'd1; expv = {1'b1, 1'b0, (mask >> 1) + 32'd1}; end
            default: begin a = 32'd5; b = 32'd7; sub = 1'b1; expv = {1'b0, 1'b0, mask - 32'd1}; end
         endcase
         in_valid  = 1'b1;
         out_ready = 1'b1;
         @(negedge clk);
         n_vec++;
         if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready sel=%0d got=%b exp=1", s, o_in_ready); end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat = 1;
         @(negedge clk);
         while (!o_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
         end
         n_vec++;
         if (lat != cfg_s(s)) begin n_err++; $display("FAIL basic_latency sel=%0d vec=%0d got=%0d exp=%0d", s, i, lat, cfg_s(s)); end
         n_vec++;
         if ({o_ovf, o_cout, o_sum} !== expv) begin
            n_err++;
            $display("FAIL basic_result sel=%0d vec=%0d got=%h exp=%h", s, i, {o_ovf, o_cout, o_sum}, expv);
         end
         @(posedge clk);
         #1;
         @(negedge clk);
         n_vec++;
         if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_dup sel=%0d vec=%0d got=%b exp=0", s, i, o_out_valid); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back(input int s);
      int cyc, occ;
      logic exp_rdy;
      sel = s;
      do_reset();
      cyc = 0;
      while (got_q.size() < 8 && cyc < 300) begin
         in_valid  = (exp_q.size() < 8);
         a         = $urandom;
         b         = $urandom;
         c_in      = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         out_ready = (cyc % 2 == 0);
         @(negedge clk);
         occ     = exp_q.size() - got_q.size();
         exp_rdy = (occ < cfg_s(s)) || out_ready;
         n_vec++;
         if (o_in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL b2b_in_ready sel=%0d cyc=%0d got=%b exp=%b", s, cyc, o_in_ready, exp_rdy);
         end
         xfer();
         cyc++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (got_q.size() != 8) begin n_err++; $display("FAIL b2b_count sel=%0d got=%0d exp=8", s, got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_result sel=%0d idx=%0d got=%h exp=%h", s, i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_stall(input int s);
      int cyc;
      sel = s;
      do_reset();
      cyc = 0;
      while (exp_q.size() < cfg_s(s) && cyc < 50) begin
         in_valid = 1'b1;
         a        = $urandom;
         b        = $urandom;
         c_in     = 1'($urandom_range(0, 1));
         sub      = 1'($urandom_range(0, 1));
         @(negedge clk);
         xfer();
         cyc++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (exp_q.size() != cfg_s(s)) begin n_err++; $display("FAIL stall_fill sel=%0d got=%0d exp=%0d", s, exp_q.size(), cfg_s(s)); end
      for (int i = 0; i < 3 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         n_vec++;
         if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready sel=%0d got=%b exp=0", s, o_in_ready); end
         n_vec++;
         if ({o_out_valid, o_ovf, o_cout, o_sum} !== {1'b1, exp_q[0]}) begin
            n_err++;
            $display("FAIL stall_hold sel=%0d got=%h exp=%h", s, {o_out_valid, o_ovf, o_cout, o_sum}, {1'b1, exp_q[0]});
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = $urandom;
      b         = $urandom;
      c_in      = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_vec++;
      if ({o_in_ready, o_out_valid} !== 2'b11) begin
         n_err++;
         $display("FAIL stall_pop_push sel=%0d got=%b exp=11", s, {o_in_ready, o_out_valid});
      end
      xfer();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      n_vec++;
      if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_still_full sel=%0d got=%b exp=0", s, o_in_ready); end
      if (exp_q.size() > 1) begin
         n_vec++;
         if ({o_out_valid, o_ovf, o_cout, o_sum} !== {1'b1, exp_q[1]}) begin
            n_err++;
            $display("FAIL stall_next_head sel=%0d got=%h exp=%h", s, {o_out_valid, o_ovf, o_cout, o_sum}, {1'b1, exp_q[1]});
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      cyc = 0;
      while (got_q.size() < exp_q.size() && cyc < 100) begin
         @(negedge clk);
         xfer();
         cyc++;
      end
      n_vec++;
      if (got_q.size() != cfg_s(s) + 1) begin n_err++; $display("FAIL stall_count sel=%0d got=%0d exp=%0d", s, got_q.size(), cfg_s(s) + 1); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_result sel=%0d idx=%0d got=%h exp=%h", s, i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid(input int s);
      int n, cyc;
      sel = s;
      do_reset();
      n   = (cfg_s(s) < 3) ? cfg_s(s) : 3;
      cyc = 0;
      while (exp_q.size() < n && cyc < 50) begin
         in_valid = 1'b1;
         a        = $urandom;
         b        = $urandom;
         c_in     = 1'($urandom_range(0, 1));
         sub      = 1'($urandom_range(0, 1));
         @(negedge clk);
         xfer();
         cyc++;
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({o_out_valid, o_in_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL midreset_flush sel=%0d got=%b exp=01", s, {o_out_valid, o_in_ready});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_stale sel=%0d cyc=%0d got=%b exp=0", s, i, o_out_valid); end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      sel       = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      c_in      = 1'b0;
      sub       = 1'b0;
      a         = '0;
      b         = '0;
      test_reset();
      for (int s = 0; s < 3; s++) begin
         test_basic(s);
         test_back_to_back(s);
         test_stall(s);
         test_reset_mid(s);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_addsub_n.md
Name: pipe_addsub_n

Overview:
Parametrised, pipelined add/subtract unit that generalises the team's fixed 4-bit full adder to WIDTH bits.
- The carry chain is split into SLICES register stages; each stage adds one SLICE_W-bit slice and passes its carry forward.
- Throughput is one operation per cycle. Valid/ready handshakes on input and output, with per-stage backpressure.
- Sits between operand sources and any consumer that needs wide arithmetic at high clock rate.

Parameters:
WIDTH, 16, operand/result width in bits; must be divisible by SLICES.
SLICES, 4, number of pipeline stages; SLICE_W = WIDTH/SLICES; SLICES >= 1.

Ports:
clk_i  input  1  clock, all logic on rising edge.
reset_i  input  1  synchronous, active-high reset.
in_valid_i  input  1  operand transaction valid.
in_ready_o  output  1  unit can accept a transaction this cycle.
a_i  input  WIDTH  operand A.
b_i  input  WIDTH  operand B.
c_in_i  input  1  carry-in; ignored when sub_i=1.
sub_i  input  1  0: A+B+c_in; 1: A-B, computed as A+~B+1.
out_valid_o  output  1  result valid.
out_ready_i  input  1  consumer accepts the result.
sum_o  output  WIDTH  result.
c_out_o  output  1  carry out of the MSB; in subtract mode 1 means no borrow.
ovf_o  output  1  signed two's-complement overflow.

Behaviour:
- Interface (already decided): one clock, clk_i; reset_i is synchronous and active-high.
- Reset:
  - Every stage valid bit clears to 0.
  - out_valid_o=0, sum_o=0, c_out_o=0, ovf_o=0.
  - in_ready_o=1 in the first cycle after reset deasserts.
- Handshakes:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - out_valid_o, sum_o, c_out_o and ovf_o stay stable while out_valid_o && !out_ready_i.
- Stage k (0..SLICES-1) contents: valid_k, unconsumed upper operand bits, result bits [k*SLICE_W-1:0], and the carry into slice k.
- Stage 0 capture: on accept, b is stored already inverted when sub_i=1, and carry is c_in_i or 1 accordingly.
- Stage advance: stage k loads from stage k-1 when (!valid_k || stage k+1 loads). The last stage uses the output handshake in place of "stage k+1 loads".
- in_ready_o = !valid_0 || stage 1 loads. It is combinational from out_ready_i through the stall chain; no combinational path exists from in_valid_i.
- Bubbles collapse: an empty stage accepts even if downstream is stalled.
- Latency: result is visible on out_valid_o exactly SLICES cycles after the input transfer when not stalled. Order is strictly FIFO; no drop, no duplication.
- Flags:
  - c_out_o = carry out of the final slice.
  - ovf_o = carry into MSB XOR carry out of MSB. Computed in the last stage, using operand MSBs after the B inversion.
- Boundaries:
  - SLICES=1 degenerates to a single registered adder with latency 1.
  - A full pipe with out_ready_i=0 drives in_ready_o=0 and holds all state.
  - Simultaneous output pop and input push with a full pipe: both transfers occur, and occupancy is unchanged.
  - reset_i mid-operation discards all in-flight transactions. out_valid_o=0 the cycle after, and no discarded result ever appears.
- Illegal parameterisation (WIDTH % SLICES != 0) is stopped by an elaboration-time check.

Decomposition:
- Shared package (adder_pkg): SLICE_W derivation function and the stage-register field layout constants.
- Sub-module add_slice: combinational SLICE_W-bit adder with a, b, cin, sum, cout, and carry-into-MSB output for overflow. Instantiated once per stage via generate.
- Top module holds the stage registers and handshake logic.

Test Plan:
- Reset: hold reset_i 2 cycles -> out_valid_o=0, sum_o=0, c_out_o=0, ovf_o=0, in_ready_o=1.
- Default params, a=16'hFFFF, b=16'h0001, c_in=0, sub=0, out_ready=1 -> 4 cycles later sum_o=16'h0000, c_out_o=1, ovf_o=0.
- a=16'h7FFF, b=16'h0001, c_in=0 -> sum_o=16'h8000, c_out_o=0, ovf_o=1. Separately a=16'h0005, b=16'h0007, sub=1 -> sum_o=16'hFFFE, c_out_o=0, ovf_o=0.
- 8 back-to-back random transactions with out_ready_i toggling 1,0,1,0 -> all 8 results in order matching the model; in_ready_o=0 only while the pipe is full and stalled.
- Stall then release: fill 4 stages with out_ready_i=0 -> in_ready_o=0, outputs held. Raise out_ready_i together with in_valid_i -> one pop and one push that cycle.
- Reset mid-flight with 3 transactions in flight: pulse reset_i 1 cycle -> out_valid_o=0 next cycle, no stale result in the following 10 cycles.
- Repeat scenarios 2-4 with SLICES=1 and with WIDTH=32, SLICES=8.
